// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM sector controller.
package bk_pkg;

    localparam int SECTOR_BYTES    = 512;
    localparam int SECTORS_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } bk_state_t;

endpackage

// File: rtl/bk_sector_ctrl_edge_det.sv
// Rising-edge detector bank: one registered previous value per bit.
// Latency: rise is combinational from d against the last sampled value; no backpressure.
module edge_det #(
    parameter int W = 1
) (
    input  logic         clk_sys,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev;

    // Sampling every cycle, reset included, means no spurious edge appears right after reset.
    always_ff @(posedge clk_sys) begin
        prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/bk_sector_ctrl.sv
// Backup-RAM sector sequencer: loads or saves SECTORS sectors of a mounted save image via user_io.
// Latency: input edges act one clock after they are sampled; requests held until sd_ack rises, next one issued after sd_ack falls.
module bk_sector_ctrl
    import bk_pkg::*;
#(
    parameter int SECTORS = SECTORS_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic [31:0] img_size,
    input  logic        ioctl_download,
    input  logic        save_req,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        nvram_b_we,
    output logic        bk_ena,
    output logic        bk_reset,
    output logic        busy
);

    localparam logic [5:0] LAST_LBA = 6'(SECTORS - 1);

    bk_state_t  state, state_nxt;
    logic [5:0] lba, lba_nxt;
    logic       dir, dir_nxt;          // 1 = load from image, 0 = save to image
    logic       rd_nxt, wr_nxt, ena_nxt, brst_nxt;
    logic       pend_load, pend_load_nxt;
    logic       pend_save, pend_save_nxt;

    logic [4:0] edge_in, edge_rise;
    logic       mount_rise, save_rise, dl_rise, ack_rise, ack_fall;

    // Rising edge of ~sd_ack doubles as the falling edge of sd_ack.
    assign edge_in = {~sd_ack, sd_ack, ioctl_download, save_req, img_mounted};

    edge_det #(.W(5)) u_edge (
        .clk_sys (clk_sys),
        .d       (edge_in),
        .rise    (edge_rise)
    );

    assign mount_rise = edge_rise[0];
    assign save_rise  = edge_rise[1];
    assign dl_rise    = edge_rise[2];
    assign ack_rise   = edge_rise[3];
    assign ack_fall   = edge_rise[4];

    always_comb begin
        state_nxt     = state;
        lba_nxt       = lba;
        dir_nxt       = dir;
        rd_nxt        = sd_rd;
        wr_nxt        = sd_wr;
        ena_nxt       = bk_ena;
        brst_nxt      = 1'b0;
        pend_load_nxt = pend_load;
        pend_save_nxt = pend_save;

        case (state)
            ST_IDLE: begin
                if (bk_ena && (pend_load || pend_save)) begin
                    lba_nxt   = '0;
                    dir_nxt   = pend_load;
                    rd_nxt    = pend_load;
                    wr_nxt    = ~pend_load;
                    state_nxt = ST_REQ;
                    if (pend_load) pend_load_nxt = 1'b0;
                    else           pend_save_nxt = 1'b0;
                end
            end
            ST_REQ: begin
                if (ack_rise) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (ack_fall) begin
                    // A download that cleared bk_ena lets the current sector finish, then stops quietly.
                    if (lba == LAST_LBA || !bk_ena) begin
                        state_nxt = ST_IDLE;
                        brst_nxt  = dir && bk_ena && (lba == LAST_LBA);
                    end else begin
                        lba_nxt   = lba + 6'd1;
                        rd_nxt    = dir;
                        wr_nxt    = ~dir;
                        state_nxt = ST_REQ;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (mount_rise && (|img_size)) begin
            ena_nxt       = 1'b1;
            pend_load_nxt = 1'b1;
        end
        if (save_rise && bk_ena) pend_save_nxt = 1'b1;
        if (dl_rise) begin
            ena_nxt       = 1'b0;
            pend_load_nxt = 1'b0;
            pend_save_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= ST_IDLE;
            lba       <= '0;
            dir       <= 1'b0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            bk_ena    <= 1'b0;
            bk_reset  <= 1'b0;
            pend_load <= 1'b0;
            pend_save <= 1'b0;
        end else begin
            state     <= state_nxt;
            lba       <= lba_nxt;
            dir       <= dir_nxt;
            sd_rd     <= rd_nxt;
            sd_wr     <= wr_nxt;
            bk_ena    <= ena_nxt;
            bk_reset  <= brst_nxt;
            pend_load <= pend_load_nxt;
            pend_save <= pend_save_nxt;
        end
    end

    assign sd_lba     = {26'd0, lba};
    assign busy       = (state != ST_IDLE);
    assign nvram_b_we = sd_buff_wr & sd_ack & (state == ST_XFER) & dir;

endmodule

// File: tb/tb_bk_sector_ctrl.sv
// Bench for bk_sector_ctrl: cycle table, directed sequences and randomized ops against a transaction-level model.
module tb_bk_sector_ctrl;

    localparam int SECTORS = 16;

    logic        clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset, img_mounted, ioctl_download, save_req;
    logic [31:0] img_size;
    logic        sd_ack, sd_buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, nvram_b_we, bk_ena, bk_reset, busy;

    logic host_en = 1'b0;
    logic h_ack, h_buff, m_ack, m_buff;
    assign sd_ack     = host_en ? h_ack  : m_ack;
    assign sd_buff_wr = host_en ? h_buff : m_buff;

    bk_sector_ctrl #(.SECTORS(SECTORS)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .img_mounted    (img_mounted),
        .img_size       (img_size),
        .ioctl_download (ioctl_download),
        .save_req       (save_req),
        .sd_ack         (sd_ack),
        .sd_buff_wr     (sd_buff_wr),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .nvram_b_we     (nvram_b_we),
        .bk_ena         (bk_ena),
        .bk_reset       (bk_reset),
        .busy           (busy)
    );

    int vectors = 0, miscompares = 0;
    int exp_we = 0, obs_we = 0;
    bit lba_bad = 0, rdwr_bad = 0;

    // kind: 0 = save request, 1 = load request, 2 = bk_reset cycle
    typedef struct packed { logic [1:0] kind; logic [5:0] lba; } ev_t;
    ev_t obsq[$], expq[$];

    bit m_ena, m_pl, m_ps;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin : monitor
        logic prev_req;
        if ((sd_rd || sd_wr) && !prev_req) obsq.push_back(ev_t'{sd_rd ? 2'd1 : 2'd0, sd_lba[5:0]});
        if (bk_reset)   obsq.push_back(ev_t'{2'd2, 6'd0});
        if (nvram_b_we) obs_we <= obs_we + 1;
        if (sd_lba >= SECTORS) lba_bad <= 1'b1;
        if (sd_rd && sd_wr)    rdwr_bad <= 1'b1;
        prev_req = sd_rd || sd_wr;
    end

    // user_io stand-in: random ack latency and length, random data strobes while acked.
    initial begin : host
        bit is_load;
        int d1, n;
        h_ack = 0; h_buff = 0;
        forever begin
            @(posedge clk_sys); #1;
            if (host_en && (sd_rd || sd_wr)) begin
                is_load = sd_rd;
                d1 = $urandom_range(0, 2);
                n  = $urandom_range(1, 4);
                repeat (d1) begin @(posedge clk_sys); #1; end
                h_ack = 1;
                repeat (n) begin
                    @(posedge clk_sys); #1;
                    h_buff = 1'($urandom_range(0, 1));
                    if (h_buff && is_load) exp_we++;
                end
                @(posedge clk_sys); #1;
                h_buff = 0; h_ack = 0;
            end
        end
    end

    task automatic exp_xfer(input bit load, input int count, input bit with_rst);
        for (int i = 0; i < count; i++) expq.push_back(ev_t'{load ? 2'd1 : 2'd0, 6'(i)});
        if (with_rst) expq.push_back(ev_t'{2'd2, 6'd0});
    endtask

    task automatic model_drain();
        while (m_ena && (m_pl || m_ps)) begin
            if (m_pl) begin m_pl = 0; exp_xfer(1, SECTORS, 1); end
            else      begin m_ps = 0; exp_xfer(0, SECTORS, 0); end
        end
    endtask

    task automatic check_events(input string name);
        chk({name, "_evcount"}, obsq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obsq.size(); i++)
            chk($sformatf("%s_ev%0d", name, i), {24'd0, obsq[i]}, {24'd0, expq[i]});
        obsq.delete();
        expq.delete();
    endtask

    task automatic wait_idle(input string name);
        int stable = 0, cyc = 0;
        while (stable < 4 && cyc < 3000) begin
            @(negedge clk_sys); cyc++;
            if (!busy && !sd_ack && !sd_rd && !sd_wr) stable++; else stable = 0;
        end
        chk({name, "_idle_reached"}, 32'(cyc < 3000), 1);
    endtask

    task automatic wait_xfer(input int target, input string name);
        int cyc = 0;
        while (!(busy && sd_ack && !sd_rd && !sd_wr && sd_lba == target) && cyc < 3000) begin
            @(negedge clk_sys); cyc++;
        end
        chk({name, "_xfer_reached"}, 32'(cyc < 3000), 1);
    endtask

    task automatic do_reset();
        @(negedge clk_sys); reset = 1;
        @(negedge clk_sys); reset = 0;
        m_ena = 0; m_pl = 0; m_ps = 0;
        obsq.delete(); expq.delete();
    endtask

    task automatic pulse_mount(input logic [31:0] sz);
        img_size = sz; img_mounted = 1;
        @(negedge clk_sys); img_mounted = 0;
    endtask

    task automatic pulse_save();
        save_req = 1;
        @(negedge clk_sys); save_req = 0;
    endtask

    task automatic pulse_dl();
        ioctl_download = 1;
        repeat (2) @(negedge clk_sys);
        ioctl_download = 0;
    endtask

    typedef struct {
        bit [6:0] in;   // reset, mount, size!=0, download, save_req, ack, buff_wr
        bit [1:0] rw;   // sd_rd, sd_wr
        int       lba;
        bit [3:0] o;    // bk_ena, bk_reset, busy, nvram_b_we
    } vec_t;

    function automatic vec_t mk(input bit [6:0] in, input bit [1:0] rw, input int lba, input bit [3:0] o);
        vec_t v;
        v.in = in; v.rw = rw; v.lba = lba; v.o = o;
        return v;
    endfunction

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[17];
        int   wb, eb, d, cyc, op;
        logic [31:0] sz;

        reset = 1; img_mounted = 0; img_size = 0; ioctl_download = 0; save_req = 0;
        m_ack = 0; m_buff = 0;

        tbl[0]  = mk(7'b1000000, 2'b00, 0, 4'b0000);  // reset state
        tbl[1]  = mk(7'b0110000, 2'b00, 0, 4'b1000);  // mount, size 8192
        tbl[2]  = mk(7'b0010000, 2'b10, 0, 4'b1010);  // load starts at lba 0
        tbl[3]  = mk(7'b0010010, 2'b00, 0, 4'b1010);  // ack rise drops sd_rd
        tbl[4]  = mk(7'b0010011, 2'b00, 0, 4'b1011);  // data strobe writes nvram
        tbl[5]  = mk(7'b0010001, 2'b10, 1, 4'b1010);  // ack fall: next sector
        tbl[6]  = mk(7'b0010011, 2'b00, 1, 4'b1011);
        tbl[7]  = mk(7'b0011010, 2'b00, 1, 4'b0010);  // download mid-sector
        tbl[8]  = mk(7'b0011000, 2'b00, 1, 4'b0000);  // stop, no bk_reset
        tbl[9]  = mk(7'b0010100, 2'b00, 1, 4'b0000);  // save ignored, bk_ena=0
        tbl[10] = mk(7'b0000100, 2'b00, 1, 4'b0000);
        tbl[11] = mk(7'b0100100, 2'b00, 1, 4'b0000);  // mount with size 0
        tbl[12] = mk(7'b0010100, 2'b00, 1, 4'b0000);
        tbl[13] = mk(7'b0110100, 2'b00, 1, 4'b1000);
        tbl[14] = mk(7'b0010000, 2'b10, 0, 4'b1010);
        tbl[15] = mk(7'b0010100, 2'b10, 0, 4'b1010);  // save rise while busy
        tbl[16] = mk(7'b1010000, 2'b00, 0, 4'b0000);  // reset drops request

        for (int i = 0; i < 17; i++) begin
            reset          = tbl[i].in[6];
            img_mounted    = tbl[i].in[5];
            img_size       = tbl[i].in[4] ? 32'd8192 : 32'd0;
            ioctl_download = tbl[i].in[3];
            save_req       = tbl[i].in[2];
            m_ack          = tbl[i].in[1];
            m_buff         = tbl[i].in[0];
            @(posedge clk_sys); #1;
            chk($sformatf("tbl%0d_sd_rd", i),      sd_rd,      tbl[i].rw[1]);
            chk($sformatf("tbl%0d_sd_wr", i),      sd_wr,      tbl[i].rw[0]);
            chk($sformatf("tbl%0d_sd_lba", i),     sd_lba,     tbl[i].lba);
            chk($sformatf("tbl%0d_bk_ena", i),     bk_ena,     tbl[i].o[3]);
            chk($sformatf("tbl%0d_bk_reset", i),   bk_reset,   tbl[i].o[2]);
            chk($sformatf("tbl%0d_busy", i),       busy,       tbl[i].o[1]);
            chk($sformatf("tbl%0d_nvram_b_we", i), nvram_b_we, tbl[i].o[0]);
        end

        m_ack = 0; m_buff = 0; save_req = 0;
        @(negedge clk_sys);
        host_en = 1;

        // full load after mount
        do_reset();
        wb = obs_we; eb = exp_we;
        pulse_mount(32'd8192);
        m_ena = 1; m_pl = 1; model_drain();
        wait_idle("load");
        check_events("load");
        chk("load_bk_ena", bk_ena, 1);
        chk("load_last_lba", sd_lba, SECTORS - 1);
        chk("load_nvram_we_count", obs_we - wb, exp_we - eb);

        // full save, no nvram writes
        wb = obs_we;
        pulse_save();
        m_ps = 1; model_drain();
        wait_idle("save");
        check_events("save");
        chk("save_nvram_we_count", obs_we - wb, 0);

        // empty image
        do_reset();
        pulse_mount(32'd0);
        wait_idle("mount0");
        check_events("mount0");
        chk("mount0_bk_ena", bk_ena, 0);

        // download during sector 5 of a load
        do_reset();
        pulse_mount(32'd8192);
        wait_xfer(5, "dl");
        ioctl_download = 1;
        exp_xfer(1, 6, 0);
        wait_idle("dl");
        check_events("dl");
        chk("dl_bk_ena", bk_ena, 0);
        chk("dl_sd_lba", sd_lba, 5);
        ioctl_download = 0;

        // save request arriving during a load
        do_reset();
        pulse_mount(32'd8192);
        wait_xfer(7, "ls");
        pulse_save();
        cyc = 0;
        while (!bk_reset && cyc < 3000) begin @(negedge clk_sys); cyc++; end
        d = 0;
        while (!sd_wr && d < 10) begin @(negedge clk_sys); d++; end
        chk("ls_save_start_delay_ok", 32'(cyc < 3000 && d <= 2), 1);
        exp_xfer(1, SECTORS, 1);
        exp_xfer(0, SECTORS, 0);
        wait_idle("ls");
        check_events("ls");
        chk("ls_bk_ena", bk_ena, 1);

        // reset in the middle of sector 3
        do_reset();
        pulse_mount(32'd8192);
        wait_xfer(3, "rst");
        reset = 1;
        @(negedge clk_sys);
        reset = 0;
        chk("rst_busy",   busy,   0);
        chk("rst_sd_lba", sd_lba, 0);
        chk("rst_sd_rd",  sd_rd,  0);
        chk("rst_sd_wr",  sd_wr,  0);
        chk("rst_bk_ena", bk_ena, 0);
        exp_xfer(1, 4, 0);
        wait_idle("rst");
        check_events("rst");

        // randomized op sequence checked against the transaction model
        do_reset();
        for (int it = 0; it < 14; it++) begin
            wb = obs_we; eb = exp_we;
            op = $urandom_range(0, 4);
            case (op)
                0: begin sz = 32'($urandom_range(1, 1 << 20)); pulse_mount(sz); m_ena = 1; m_pl = 1; end
                1: pulse_mount(32'd0);
                2: begin pulse_save(); if (m_ena) m_ps = 1; end
                3: begin pulse_dl(); m_ena = 0; m_pl = 0; m_ps = 0; end
                default: begin
                    pulse_mount(32'd4096); m_ena = 1; m_pl = 1;
                    repeat (5) @(negedge clk_sys);
                    pulse_save(); m_ps = 1;
                end
            endcase
            model_drain();
            wait_idle($sformatf("rnd%0d", it));
            check_events($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d_bk_ena", it), bk_ena, m_ena);
            chk($sformatf("rnd%0d_nvram_we", it), obs_we - wb, exp_we - eb);
        end

        @(negedge clk_sys);
        chk("lba_never_out_of_range", lba_bad, 0);
        chk("rd_wr_never_both", rdwr_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
